// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : risc_pkg
//  Description : Shared datapath types and constants for the RISC core:
//                word/register-index types, B-path shift codes and the ALU
//                operation codes consumed downstream of operand_stage.
//  Revision    : 1.0  initial release
// ============================================================================
package risc_pkg;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  regidx_t;

    // B-path shift codes
    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    // ALU operation codes (used by the ALU stage)
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

endpackage : risc_pkg
`default_nettype wire

// File: rtl/operand_stage_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : NREG x WIDTH general register file. One synchronous write
//                port with decoded enables, one combinational read port.
//                Reads return the pre-edge contents (no write bypass).
//  Ports       : clk, reset (sync, active-high), write, writenum, data_in,
//                readnum, data_out
//  Revision    : 1.0  initial release
// ============================================================================
module regfile
    import risc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREG  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write,
    input  logic [$clog2(NREG)-1:0] writenum,
    input  logic [WIDTH-1:0]        data_in,
    input  logic [$clog2(NREG)-1:0] readnum,
    output logic [WIDTH-1:0]        data_out
);

    logic [NREG-1:0]  w_we;
    logic [WIDTH-1:0] r_regs [NREG];

    // One-hot write enable, all zero when no write is requested.
    assign w_we = write ? (NREG'(1) << writenum) : '0;

    genvar gi;
    for (gi = 0; gi < NREG; gi++) begin : g_reg
        always_ff @(posedge clk) begin
            if (reset) begin
                r_regs[gi] <= '0;
            end else if (w_we[gi]) begin
                r_regs[gi] <= data_in;
            end
        end
    end

    assign data_out = r_regs[readnum];

endmodule : regfile
`default_nettype wire

// File: rtl/operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : operand_stage
//  Description : Operand preparation upstream of the ALU. Register file plus
//                A/B operand latches, a 1-bit shifter on the B path and the
//                asel/bsel source muxes that drive Ain/Bin.
//  Ports       : clk, reset (sync, active-high)
//                write/writenum/data_in   - register write port
//                readnum/rdata            - combinational register read
//                loada/loadb              - capture R[readnum] into A/B
//                shift, asel, bsel, sximm5 - combinational operand controls
//                Ain, Bin                 - ALU operands
//  Revision    : 1.0  initial release
// ============================================================================
module operand_stage
    import risc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREG  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write,
    input  logic [$clog2(NREG)-1:0] writenum,
    input  logic [WIDTH-1:0]        data_in,
    input  logic [$clog2(NREG)-1:0] readnum,
    input  logic                    loada,
    input  logic                    loadb,
    input  logic [1:0]              shift,
    input  logic                    asel,
    input  logic                    bsel,
    input  logic [WIDTH-1:0]        sximm5,
    output logic [WIDTH-1:0]        Ain,
    output logic [WIDTH-1:0]        Bin,
    output logic [WIDTH-1:0]        rdata
);

    logic [WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_bshift;

    regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .writenum (writenum),
        .data_in  (data_in),
        .readnum  (readnum),
        .data_out (w_rdata)
    );

    // Latches capture the pre-edge register value, so a same-edge write to
    // the selected register is not forwarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            if (loada) r_a <= w_rdata;
            if (loadb) r_b <= w_rdata;
        end
    end

    always_comb begin
        w_bshift = r_b;
        case (shift)
            SH_NONE: w_bshift = r_b;
            SH_LSL:  w_bshift = {r_b[WIDTH-2:0], 1'b0};
            SH_LSR:  w_bshift = {1'b0, r_b[WIDTH-1:1]};
            SH_ASR:  w_bshift = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
            default: w_bshift = r_b;
        endcase
    end

    assign Ain   = asel ? '0 : r_a;
    assign Bin   = bsel ? sximm5 : w_bshift;
    assign rdata = w_rdata;

endmodule : operand_stage
`default_nettype wire

// File: tb/tb_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_stage
//  Description : Self-checking bench for operand_stage: directed scenarios
//                followed by randomized traffic against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic [2:0]  readnum;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [15:0] sximm5;
    logic [15:0] Ain;
    logic [15:0] Bin;
    logic [15:0] rdata;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [15:0] m_r [8];
    logic [15:0] m_a;
    logic [15:0] m_b;

    operand_stage #(.WIDTH(16), .NREG(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .writenum (writenum),
        .data_in  (data_in),
        .readnum  (readnum),
        .loada    (loada),
        .loadb    (loadb),
        .shift    (shift),
        .asel     (asel),
        .bsel     (bsel),
        .sximm5   (sximm5),
        .Ain      (Ain),
        .Bin      (Bin),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    // Shift rules expressed as arithmetic on the 16-bit value.
    function automatic logic [15:0] model_shift(input logic [15:0] v, input logic [1:0] code);
        int unsigned x;
        x = v;
        case (code)
            2'd0:    return v;
            2'd1:    return 16'((x * 2) % 65536);
            2'd2:    return 16'(x / 2);
            default: return 16'(x / 2 + (x & 32'h8000));
        endcase
    endfunction

    function automatic logic [15:0] exp_ain();
        return asel ? 16'h0000 : m_a;
    endfunction

    function automatic logic [15:0] exp_bin();
        return bsel ? sximm5 : model_shift(m_b, shift);
    endfunction

    // Update the model from the pre-edge inputs, then advance one clock.
    task automatic step();
        logic [15:0] old;
        old = m_r[readnum];
        if (reset) begin
            for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
            m_a = 16'h0000;
            m_b = 16'h0000;
        end else begin
            if (loada) m_a = old;
            if (loadb) m_b = old;
            if (write) m_r[writenum] = data_in;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; write = 0; writenum = 0; data_in = 0; readnum = 0;
        loada = 0; loadb = 0; shift = 2'b00; asel = 0; bsel = 0; sximm5 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            readnum = 3'(i);
            #1;
            vectors++;
            if (rdata !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_rdata[%0d]: got %h expected 0000", i, rdata);
            end
        end
        readnum = 0; loada = 1; loadb = 1;
        step();
        loada = 0; loadb = 0;
        vectors++;
        if (Ain !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_ain: got %h expected 0000", Ain);
        end
        vectors++;
        if (Bin !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_bin: got %h expected 0000", Bin);
        end
        bsel = 1; sximm5 = 16'h5A5A;
        #1;
        vectors++;
        if (Bin !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL reset_bin_imm: got %h expected 5a5a", Bin);
        end
        bsel = 0; sximm5 = 0;
    endtask

    task automatic test_shift();
        logic [15:0] exp_tab [3];
        exp_tab[0] = 16'h00F0; exp_tab[1] = 16'h01E0; exp_tab[2] = 16'h0078;
        write = 1; writenum = 3; data_in = 16'h00F0;
        step();
        write = 0; readnum = 3; loadb = 1;
        step();
        loadb = 0;
        for (int s = 0; s < 3; s++) begin
            shift = 2'(s);
            #1;
            vectors++;
            if (Bin !== exp_tab[s] || Bin !== exp_bin()) begin
                miscompares++;
                $display("FAIL shift_r3 code=%0d: got %h expected %h", s, Bin, exp_tab[s]);
            end
        end
        shift = 0;
    endtask

    task automatic test_asr();
        logic [15:0] exp_tab [4];
        exp_tab[1] = 16'h0002; exp_tab[2] = 16'h4000; exp_tab[3] = 16'hC000; exp_tab[0] = 16'h8001;
        write = 1; writenum = 5; data_in = 16'h8001;
        step();
        write = 0; readnum = 5; loadb = 1;
        step();
        loadb = 0;
        for (int s = 3; s >= 0; s--) begin
            shift = 2'(s);
            #1;
            vectors++;
            if (Bin !== exp_tab[s] || Bin !== exp_bin()) begin
                miscompares++;
                $display("FAIL shift_r5 code=%0d: got %h expected %h", s, Bin, exp_tab[s]);
            end
        end
        shift = 0;
    endtask

    task automatic test_same_edge();
        write = 1; writenum = 2; data_in = 16'h0007;
        step();
        writenum = 2; data_in = 16'h1234; readnum = 2; loada = 1;
        step();
        write = 0; loada = 0;
        vectors++;
        if (Ain !== 16'h0007) begin
            miscompares++;
            $display("FAIL same_edge_a_old: got %h expected 0007", Ain);
        end
        vectors++;
        if (rdata !== 16'h1234) begin
            miscompares++;
            $display("FAIL same_edge_reg_new: got %h expected 1234", rdata);
        end
        loada = 1;
        step();
        loada = 0;
        vectors++;
        if (Ain !== 16'h1234) begin
            miscompares++;
            $display("FAIL same_edge_second_load: got %h expected 1234", Ain);
        end
    endtask

    task automatic test_mux();
        write = 1; writenum = 4; data_in = 16'hABCD;
        step();
        write = 0; readnum = 4; loada = 1; loadb = 1;
        step();
        loada = 0; loadb = 0;
        asel = 1;
        #1;
        vectors++;
        if (Ain !== 16'h0000) begin
            miscompares++;
            $display("FAIL mux_asel1: got %h expected 0000", Ain);
        end
        asel = 0;
        #1;
        vectors++;
        if (Ain !== 16'hABCD) begin
            miscompares++;
            $display("FAIL mux_asel0: got %h expected abcd", Ain);
        end
        bsel = 1; sximm5 = 16'hFFF0;
        for (int s = 0; s < 4; s++) begin
            shift = 2'(s);
            #1;
            vectors++;
            if (Bin !== 16'hFFF0) begin
                miscompares++;
                $display("FAIL mux_bsel1 shift=%0d: got %h expected fff0", s, Bin);
            end
        end
        bsel = 0; shift = 0; sximm5 = 0;
    endtask

    task automatic test_reset_priority();
        write = 1; writenum = 1; data_in = 16'h3333;
        step();
        reset = 1; writenum = 1; data_in = 16'hFFFF; readnum = 1; loada = 1;
        step();
        reset = 0; write = 0; loada = 0;
        vectors++;
        if (rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_prio_r1: got %h expected 0000", rdata);
        end
        vectors++;
        if (Ain !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_prio_a: got %h expected 0000", Ain);
        end
        loada = 1;
        step();
        loada = 0;
        vectors++;
        if (Ain !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_prio_reload: got %h expected 0000", Ain);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            reset    = ($urandom_range(0, 39) == 0);
            write    = $urandom_range(0, 1) == 1;
            writenum = 3'($urandom_range(0, 7));
            data_in  = 16'($urandom);
            readnum  = 3'($urandom_range(0, 7));
            loada    = $urandom_range(0, 2) == 0;
            loadb    = $urandom_range(0, 2) == 0;
            step();
            reset = 0; write = 0; loada = 0; loadb = 0;
            shift  = 2'($urandom_range(0, 3));
            asel   = $urandom_range(0, 3) == 0;
            bsel   = $urandom_range(0, 3) == 0;
            sximm5 = 16'($urandom);
            readnum = 3'($urandom_range(0, 7));
            #1;
            vectors++;
            if (Ain !== exp_ain()) begin
                miscompares++;
                $display("FAIL rand_ain #%0d: got %h expected %h", n, Ain, exp_ain());
            end
            vectors++;
            if (Bin !== exp_bin()) begin
                miscompares++;
                $display("FAIL rand_bin #%0d: got %h expected %h", n, Bin, exp_bin());
            end
            vectors++;
            if (rdata !== m_r[readnum]) begin
                miscompares++;
                $display("FAIL rand_rdata #%0d r%0d: got %h expected %h", n, readnum, rdata, m_r[readnum]);
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
        m_a = 16'h0000;
        m_b = 16'h0000;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_shift();
        test_asr();
        test_same_edge();
        test_mux();
        test_reset_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_operand_stage
`default_nettype wire
